riscv_fpu_writeback: RTL and testbench

// - Writeback stage directly downstream of the FPU datapath.
// - Buffers FPU results in a small FIFO. NaN-boxes single-precision FP results. Sign-extends FP->int results.
// - Drives the FP and integer register-file write ports.
// - Owns the sticky fcsr state (fflags/frm): accumulates per-op exception flags, serves CSR reads/writes.

---
 rtl/riscv_fpu_writeback.sv | 140 ++++++++++++++
 tb/tb_riscv_fpu_writeback.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_fpu_writeback.sv
// FPU writeback stage: result FIFO, NaN-boxing / sign-extension, RF write ports
// and the sticky fcsr (fflags/frm) state.
module riscv_fpu_writeback #(
    parameter int XLEN  = 64,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      in_rd,
    input  logic [XLEN-1:0] in_result,
    input  logic [4:0]      in_flags,
    input  logic            in_is_double,
    input  logic            in_to_int,
    input  logic            wb_stall,
    output logic            fp_wr_en,
    output logic [4:0]      fp_wr_addr,
    output logic [XLEN-1:0] fp_wr_data,
    output logic            int_wr_en,
    output logic [4:0]      int_wr_addr,
    output logic [XLEN-1:0] int_wr_data,
    input  logic            csr_we,
    input  logic [11:0]     csr_addr,
    input  logic [7:0]      csr_wdata,
    output logic [7:0]      csr_rdata,
    output logic [2:0]      frm,
    output logic            frm_invalid,
    output logic            fs_dirty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    typedef struct packed {
        logic [4:0]      rd;
        logic [XLEN-1:0] result;
        logic [4:0]      flags;
        logic            is_double;
        logic            to_int;
    } entry_t;

    entry_t        mem [DEPTH];
    entry_t        head;
    logic [AW-1:0] wptr, rptr;
    logic [AW:0]   count;
    logic          empty, full, push, head_fire;
    logic [31:0]   lo;
    logic [4:0]    fflags, fflags_nxt;
    logic [2:0]    frm_nxt;
    logic          dirty_nxt, csr_hit, csr_ff, csr_fr;

    assign head      = mem[rptr];
    assign empty     = (count == '0);
    assign full      = (count == FULL_CNT);
    assign in_ready  = !rst && !full;
    assign push      = in_valid && in_ready;
    assign head_fire = !empty && !wb_stall;
    assign lo        = head.result[31:0];

    assign fp_wr_en    = head_fire && !head.to_int;
    assign int_wr_en   = head_fire && head.to_int && (head.rd != 5'd0);
    assign fp_wr_addr  = empty ? 5'd0 : head.rd;
    assign int_wr_addr = empty ? 5'd0 : head.rd;

    // Singles are NaN-boxed for the FP file and sign-extended for the int file
    always_comb begin
        fp_wr_data  = '0;
        int_wr_data = '0;
        if (!empty) begin
            fp_wr_data  = head.is_double ? head.result
                                         : {{(XLEN-32){1'b1}}, lo};
            int_wr_data = head.is_double ? head.result
                                         : {{(XLEN-32){lo[31]}}, lo};
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wptr] <= '{rd: in_rd, result: in_result, flags: in_flags,
                           is_double: in_is_double, to_int: in_to_int};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push)
                wptr <= wptr + 1'b1;
            if (head_fire)
                rptr <= rptr + 1'b1;
            if (push && !head_fire)
                count <= count + 1'b1;
            else if (!push && head_fire)
                count <= count - 1'b1;
        end
    end

    assign csr_hit = csr_we && (csr_addr >= 12'h001) && (csr_addr <= 12'h003);
    assign csr_ff  = csr_we && (csr_addr == 12'h001 || csr_addr == 12'h003);
    assign csr_fr  = csr_we && (csr_addr == 12'h002 || csr_addr == 12'h003);

    // A retiring op's flags are ORed in even over a same-edge CSR write
    always_comb begin
        fflags_nxt = csr_ff ? csr_wdata[4:0] : fflags;
        if (head_fire)
            fflags_nxt = fflags_nxt | head.flags;
        frm_nxt = frm;
        if (csr_fr)
            frm_nxt = (csr_addr == 12'h003) ? csr_wdata[7:5] : csr_wdata[2:0];
        dirty_nxt = fp_wr_en || csr_hit ||
                    (head_fire && ((head.flags & ~fflags) != 5'd0));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fflags   <= '0;
            frm      <= '0;
            fs_dirty <= 1'b0;
        end else begin
            fflags   <= fflags_nxt;
            frm      <= frm_nxt;
            fs_dirty <= dirty_nxt;
        end
    end

    always_comb begin
        case (csr_addr)
            12'h001: csr_rdata = {3'b000, fflags};
            12'h002: csr_rdata = {5'b00000, frm};
            12'h003: csr_rdata = {frm, fflags};
            default: csr_rdata = 8'h00;
        endcase
    end

    assign frm_invalid = (frm >= 3'd5);

endmodule

// File: tb/tb_riscv_fpu_writeback.sv
// Scoreboard bench for riscv_fpu_writeback: directed cases plus random traffic
// checked against a queue model of the expected register-file writes.
module tb_riscv_fpu_writeback;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  in_rd = '0;
    logic [63:0] in_result = '0;
    logic [4:0]  in_flags = '0;
    logic        in_is_double = 1'b0;
    logic        in_to_int = 1'b0;
    logic        wb_stall = 1'b0;
    logic        fp_wr_en, int_wr_en;
    logic [4:0]  fp_wr_addr, int_wr_addr;
    logic [63:0] fp_wr_data, int_wr_data;
    logic        csr_we = 1'b0;
    logic [11:0] csr_addr = '0;
    logic [7:0]  csr_wdata = '0;
    logic [7:0]  csr_rdata;
    logic [2:0]  frm;
    logic        frm_invalid, fs_dirty;

    riscv_fpu_writeback #(.XLEN(64), .DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd),
        .in_result(in_result), .in_flags(in_flags),
        .in_is_double(in_is_double), .in_to_int(in_to_int),
        .wb_stall(wb_stall),
        .fp_wr_en(fp_wr_en), .fp_wr_addr(fp_wr_addr), .fp_wr_data(fp_wr_data),
        .int_wr_en(int_wr_en), .int_wr_addr(int_wr_addr),
        .int_wr_data(int_wr_data),
        .csr_we(csr_we), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
        .csr_rdata(csr_rdata), .frm(frm), .frm_invalid(frm_invalid),
        .fs_dirty(fs_dirty)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;
    logic [69:0] exp_q[$];
    logic [4:0] acc;

    task automatic chk(input string name, input logic [69:0] act,
                       input logic [69:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: what the register files should receive for one accepted op
    task automatic model_push(input logic [4:0] rd, input logic [63:0] r,
                              input logic dbl, input logic ti);
        logic [63:0] d;
        if (ti && rd == 5'd0) return;
        if (dbl)     d = r;
        else if (ti) d = 64'(longint'(int'(r[31:0])));
        else         d = {32'hFFFF_FFFF, r[31:0]};
        exp_q.push_back({ti, rd, d});
    endtask

    task automatic push_op(input logic [4:0] rd, input logic [63:0] r,
                           input logic [4:0] fl, input logic dbl,
                           input logic ti);
        bit done = 0;
        in_valid = 1'b1; in_rd = rd; in_result = r;
        in_flags = fl; in_is_double = dbl; in_to_int = ti;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                model_push(rd, r, dbl, ti);
                done = 1;
            end
            tick();
        end
        if (!done) chk("push_timeout", 70'd0, 70'd1);
        in_valid = 1'b0;
    endtask

    task automatic csr_write(input logic [11:0] a, input logic [7:0] d);
        csr_we = 1'b1; csr_addr = a; csr_wdata = d;
        tick();
        csr_we = 1'b0;
    endtask

    task automatic read_fflags(output logic [7:0] v);
        csr_addr = 12'h001;
        #1 v = csr_rdata;
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick();
        repeat (3) tick();
        if (exp_q.size() != 0) chk("drain_timeout", 70'(exp_q.size()), 70'd0);
    endtask

    // Monitor: every write the DUT presents must match the queue head
    initial begin
        logic [69:0] act, e;
        forever begin
            @(negedge clk);
            if (fp_wr_en || int_wr_en) begin
                act = int_wr_en ? {1'b1, int_wr_addr, int_wr_data}
                                : {1'b0, fp_wr_addr, fp_wr_data};
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_write: got %h expected none", act);
                end else begin
                    e = exp_q.pop_front();
                    chk("wb_write", act, e);
                end
            end
        end
    end

    initial begin
        logic [7:0] v;
        csr_addr = 12'h003;
        #12;
        chk("rst_in_ready", 70'(in_ready), 70'd0);
        chk("rst_outputs", 70'({fp_wr_en, int_wr_en, frm, fs_dirty, csr_rdata}), 70'd0);
        @(posedge clk); #1 rst = 1'b0;
        tick();

        push_op(5'd3, 64'h1234_5678_3F80_0000, 5'd0, 1'b0, 1'b0);
        @(negedge clk);
        chk("single_fp_en", 70'(fp_wr_en), 70'd1);
        chk("single_fp_addr", 70'(fp_wr_addr), 70'd3);
        chk("single_fp_data", 70'(fp_wr_data), 70'h0_FFFF_FFFF_3F80_0000);
        tick();

        push_op(5'd5, 64'hDEAD_BEEF_8000_0001, 5'd0, 1'b0, 1'b1);
        @(negedge clk);
        chk("sext_int_data", 70'(int_wr_data), 70'h0_FFFF_FFFF_8000_0001);
        tick();

        csr_write(12'h001, 8'h00);
        push_op(5'd0, 64'h0000_0000_8000_0001, 5'b01000, 1'b0, 1'b1);
        drain();
        read_fflags(v);
        chk("rd0_flags", 70'(v), 70'h08);

        wb_stall = 1'b1;
        push_op(5'd10, 64'h1111_2222_3333_4444, 5'd0, 1'b1, 1'b0);
        push_op(5'd11, 64'h5555_6666_7777_8888, 5'd0, 1'b1, 1'b0);
        in_valid = 1'b1; in_rd = 5'd12;
        @(negedge clk);
        chk("full_in_ready", 70'(in_ready), 70'd0);
        chk("stalled_no_write", 70'(fp_wr_en), 70'd0);
        tick();
        in_valid = 1'b0; wb_stall = 1'b0;
        @(negedge clk);
        chk("retire1", 70'({fp_wr_en, fp_wr_addr}), 70'({1'b1, 5'd10}));
        tick();
        @(negedge clk);
        chk("retire2", 70'({fp_wr_en, fp_wr_addr}), 70'({1'b1, 5'd11}));
        tick();
        @(negedge clk);
        chk("drained_ready", 70'({in_ready, fp_wr_en}), 70'b10);
        tick();

        csr_write(12'h001, 8'h00);
        push_op(5'd1, 64'd1, 5'b00001, 1'b1, 1'b0);
        push_op(5'd2, 64'd2, 5'b10000, 1'b1, 1'b0);
        drain();
        read_fflags(v);
        chk("flags_or", 70'(v), 70'h11);

        wb_stall = 1'b1;
        push_op(5'd4, 64'd4, 5'b00100, 1'b1, 1'b0);
        csr_we = 1'b1; csr_addr = 12'h001; csr_wdata = 8'h00; wb_stall = 1'b0;
        tick();
        csr_we = 1'b0;
        read_fflags(v);
        chk("csr_pop_same_edge", 70'(v), 70'h04);
        drain();

        csr_write(12'h003, 8'hE3);
        @(negedge clk);
        chk("fcsr_frm", 70'({frm, frm_invalid}), 70'({3'd7, 1'b1}));
        chk("fcsr_rdata", 70'(csr_rdata), 70'hE3);
        chk("fcsr_dirty", 70'(fs_dirty), 70'd1);
        read_fflags(v);
        chk("fcsr_fflags", 70'(v), 70'h03);
        tick();
        @(negedge clk);
        chk("dirty_one_cycle", 70'(fs_dirty), 70'd0);
        tick();
        csr_write(12'h002, 8'h02);
        csr_addr = 12'h002;
        #1 chk("frm_write", 70'({csr_rdata, frm_invalid}), 70'({8'h02, 1'b0}));

        csr_write(12'h001, 8'h00);
        acc = '0;
        for (int i = 0; i < 400; i++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            wb_stall = ($urandom_range(0, 3) == 0);
            in_rd = 5'($urandom_range(0, 31));
            in_result = {$urandom, $urandom};
            in_flags = 5'($urandom_range(0, 31));
            in_is_double = 1'($urandom_range(0, 1));
            in_to_int = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (in_valid && in_ready) begin
                model_push(in_rd, in_result, in_is_double, in_to_int);
                acc = acc | in_flags;
            end
            tick();
        end
        in_valid = 1'b0; wb_stall = 1'b0;
        drain();
        read_fflags(v);
        chk("random_fflags", 70'(v), 70'(acc));

        csr_write(12'h003, 8'hFF);
        wb_stall = 1'b1;
        push_op(5'd7, 64'd7, 5'd0, 1'b1, 1'b0);
        push_op(5'd8, 64'd8, 5'd0, 1'b1, 1'b1);
        rst = 1'b1;
        exp_q.delete();
        csr_addr = 12'h003;
        @(negedge clk);
        chk("midrst_outputs", 70'({in_ready, fp_wr_en, int_wr_en, csr_rdata, frm}), 70'd0);
        tick();
        rst = 1'b0; wb_stall = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        chk("postrst_ready", 70'(in_ready), 70'd1);
        read_fflags(v);
        chk("postrst_fflags", 70'(v), 70'd0);
        tick();

        chk("queue_empty", 70'(exp_q.size()), 70'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
